// File: rtl/enc_64_6_stream_pkg.sv
// enc_64_6_stream_pkg: shared widths and state encoding for the mask-to-index streamer
package enc_64_6_stream_pkg;
  localparam int W  = 64;
  localparam int IW = 6;
  localparam int G  = 8;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;
endpackage

// File: rtl/enc_64_6_stream_if.sv
// enc_64_6_stream_if: mask-in / index-out handshake bundle
interface enc_64_6_stream_if;
  import enc_64_6_stream_pkg::*;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_none;
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none
  );
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none
  );
endinterface

// File: rtl/enc_64_6_stream_enc_8_3.sv
// enc_8_3: combinational lowest-set-bit encoder for one 8-bit group
module enc_8_3 (
  input  logic [7:0] i_in,
  output logic [2:0] o_idx,
  output logic       o_any
);
  // scan high to low so the lowest set bit wins
  always_comb begin
    o_idx = '0;
    for (int k = 7; k >= 0; k--) if (i_in[k]) o_idx = 3'(k);
  end
  assign o_any = |i_in;
endmodule

// File: rtl/enc_64_6_stream.sv
// enc_64_6_stream: streams the index of every set mask bit, lowest first, one per handshake
module enc_64_6_stream
  import enc_64_6_stream_pkg::*;
(
  input logic              clk,
  input logic              rst,
  enc_64_6_stream_if.slave bus
);
  logic [0:0]    r_state;
  logic [W-1:0]  r_mask;
  logic          r_none;
  logic [G-1:0]  w_grp_any;
  logic [2:0]    w_bit_idx [G];
  logic [2:0]    w_grp_idx;
  logic          w_any;
  logic          w_single;
  logic          w_last;
  logic          w_emit;
  logic [IW-1:0] w_idx;
  genvar g;
  for (g = 0; g < G; g++) begin : g_grp
    enc_8_3 u_enc (
      .i_in  (r_mask[g*G +: G]),
      .o_idx (w_bit_idx[g]),
      .o_any (w_grp_any[g])
    );
  end
  enc_8_3 u_sel (
    .i_in  (w_grp_any),
    .o_idx (w_grp_idx),
    .o_any (w_any)
  );
  assign w_emit   = r_state == S_EMIT;
  assign w_idx    = {w_grp_idx, w_bit_idx[w_grp_idx]};
  assign w_single = w_any && ((r_mask & (r_mask - W'(1))) == '0);
  assign w_last   = w_single || r_none;
  assign bus.in_ready  = !w_emit;
  assign bus.out_valid = w_emit;
  assign bus.out_idx   = w_emit ? w_idx : '0;
  assign bus.out_last  = w_emit && w_last;
  assign bus.out_none  = w_emit && r_none;
  // load a mask in IDLE, retire one bit per accepted beat in EMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_none  <= 1'b0;
    end else if (!w_emit) begin
      if (bus.in_valid) begin
        r_mask  <= bus.in_vec;
        r_none  <= bus.in_vec == '0;
        r_state <= S_EMIT;
      end
    end else if (bus.out_ready) begin
      r_mask[w_idx] <= 1'b0;
      if (w_last) r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_enc_64_6_stream.sv
// tb_enc_64_6_stream: table, directed and random checks against a set-bit queue model
module tb_enc_64_6_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  enc_64_6_stream_if bus ();
  enc_64_6_stream dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [63:0] mask;
    int          mode;
    int          beats;
    int          first;
    int          last;
  } vec_t;
  vec_t tbl [7];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic chk_idle(input string name);
    chk(name, {58'd0, bus.out_valid, bus.in_ready, bus.out_last, bus.out_none, 2'd0} | 64'(bus.out_idx),
        {58'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
  endtask
  task automatic run_mask(input logic [63:0] m, input int mode, output int cnt, output int first, output int lastv);
    int q[$];
    bit nn;
    int k;
    int cyc;
    logic rdy;
    for (int i = 0; i < 64; i++) if (m[i]) q.push_back(i);
    nn = q.size() == 0;
    if (nn) q.push_back(0);
    cnt = 0; first = -1; lastv = -1; k = 0; cyc = 0;
    chk("ready_before_load", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_vec   = m;
    step();
    bus.in_valid = 1'b0;
    bus.in_vec   = {$urandom, $urandom};
    while (k < q.size() && cyc < 400) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      chk("beat", {54'd0, bus.out_valid, bus.in_ready, bus.out_none, bus.out_last, bus.out_idx},
          {54'd0, 1'b1, 1'b0, nn, 1'(k == q.size() - 1), 6'(q[k])});
      if (rdy) begin
        if (k == 0) first = int'(bus.out_idx);
        lastv = int'(bus.out_idx);
        cnt++;
        k++;
      end
      step();
      cyc++;
    end
    if (k < q.size()) chk("beat_timeout", 64'(k), 64'(q.size()));
    bus.out_ready = 1'b1;
    chk_idle("idle_after_mask");
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    int cnt, first, lastv, dens;
    logic [63:0] m;
    tbl[0] = '{64'h8000_0000_0000_0011, 0, 3, 0, 63};
    tbl[1] = '{64'h0, 0, 1, 0, 0};
    tbl[2] = '{64'h1, 0, 1, 0, 0};
    tbl[3] = '{64'h8000_0000_0000_0000, 0, 1, 63, 63};
    tbl[4] = '{64'h0000_0100_0000_0001, 2, 2, 0, 40};
    tbl[5] = '{64'h00F0_0000_0000_0000, 1, 4, 52, 55};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 64, 0, 63};
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    chk_idle("reset_state");
    rst = 1'b0;
    step();
    chk_idle("idle_after_reset");
    for (int t = 0; t < 7; t++) begin
      run_mask(tbl[t].mask, tbl[t].mode, cnt, first, lastv);
      chk("tbl_beats", 64'(cnt), 64'(tbl[t].beats));
      chk("tbl_first", 64'(first), 64'(tbl[t].first));
      chk("tbl_last", 64'(lastv), 64'(tbl[t].last));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_vec    = 64'h0000_0100_0000_0001;
    step();
    bus.in_valid = 1'b0;
    chk("rst_mid_first", {57'd0, bus.out_valid, bus.out_idx}, {57'd0, 1'b1, 6'd0});
    step();
    chk("rst_mid_pending", {57'd0, bus.out_valid, bus.out_idx}, {57'd0, 1'b1, 6'd40});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rst_mid_idle");
    step();
    chk_idle("rst_mid_still_idle");
    run_mask(64'h2, 0, cnt, first, lastv);
    chk("after_rst_mask", 64'(first), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_vec   = 64'h5;
    step();
    bus.in_vec = 64'h2;
    chk("hold_a0", {56'd0, bus.in_ready, bus.out_last, bus.out_idx}, {56'd0, 1'b0, 1'b0, 6'd0});
    step();
    chk("hold_a2", {56'd0, bus.in_ready, bus.out_last, bus.out_idx}, {56'd0, 1'b0, 1'b1, 6'd2});
    step();
    chk("hold_gap_idle", {62'd0, bus.in_ready, bus.out_valid}, {62'd0, 1'b1, 1'b0});
    step();
    bus.in_valid = 1'b0;
    chk("hold_b1", {55'd0, bus.out_valid, bus.out_last, bus.out_none, bus.out_idx}, {55'd0, 1'b1, 1'b1, 1'b0, 6'd1});
    step();
    chk_idle("hold_done");
    for (int r = 0; r < 40; r++) begin
      dens = $urandom_range(0, 3);
      m = {$urandom, $urandom};
      for (int d = 0; d < dens; d++) m = m & {$urandom, $urandom};
      if (r % 10 == 9) m = '0;
      run_mask(m, $urandom_range(0, 2), cnt, first, lastv);
      chk("rand_beats", 64'(cnt), m == '0 ? 64'd1 : 64'($countones(m)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
